// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared pipeline constants and fetch state encoding
package fetch_unit_pkg;

    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        IDLE,
        WAIT
    } fetchState_t;

endpackage

// File: rtl/if_id_reg.sv
// rtl/if_id_reg.sv - pipeline stage register with stall, flush and load-select
module if_id_reg #(
    parameter int          XLEN      = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            load,
    input  logic [31:0]     loadInstr,
    input  logic [XLEN-1:0] loadPC,
    input  logic [XLEN-1:0] loadPCPlus4,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    // Bubbles keep the PC fields so a later stall-hold still shows the last PC.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            InstrD   <= NOP_INSTR;
            PCD      <= '0;
            PCPlus4D <= '0;
            ValidD   <= 1'b0;
        end else if (flush) begin
            InstrD   <= NOP_INSTR;
            ValidD   <= 1'b0;
        end else if (!stall) begin
            if (load) begin
                InstrD   <= loadInstr;
                PCD      <= loadPC;
                PCPlus4D <= loadPCPlus4;
                ValidD   <= 1'b1;
            end else begin
                InstrD   <= NOP_INSTR;
                ValidD   <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch: PCF, one-outstanding imem request, skid buffer, IF/ID
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = XLEN'(fetch_unit_pkg::RESET_PC),
    parameter logic [31:0]     NOP_INSTR = fetch_unit_pkg::NOP_INSTR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallF,
    input  logic            StallD,
    input  logic            FlushD,
    input  logic            PCSrcE,
    input  logic [XLEN-1:0] PCTargetE,
    output logic            IMemReq,
    output logic [XLEN-1:0] IMemAddr,
    input  logic            IMemGnt,
    input  logic            IMemRvalid,
    input  logic [31:0]     IMemRdata,
    output logic [31:0]     InstrD,
    output logic [XLEN-1:0] PCD,
    output logic [XLEN-1:0] PCPlus4D,
    output logic            ValidD
);

    import fetch_unit_pkg::*;

    localparam logic [XLEN-1:0] FOUR = XLEN'(4);

    fetchState_t     state;
    logic [XLEN-1:0] PCF;
    logic [XLEN-1:0] ReqPC;
    logic [XLEN-1:0] BufPC;
    logic [31:0]     BufInstr;
    logic            BufValid;
    logic            Discard;

    logic            respValid;
    logic            respKeep;
    logic            respToD;
    logic            bufCapture;
    logic            grant;
    logic            loadD;
    logic [31:0]     loadInstr;
    logic [XLEN-1:0] loadPC;

    assign respValid  = (state == WAIT) & IMemRvalid;
    assign respKeep   = respValid & !Discard & !PCSrcE;
    assign respToD    = respKeep & !StallD & !FlushD;
    assign bufCapture = respKeep & StallD & !FlushD;

    // A new request may share the cycle with the response that frees the slot,
    // as long as that response has somewhere to go (dropped or straight into D).
    assign IMemReq  = !rst & !StallF & !PCSrcE & !BufValid &
                      ((state == IDLE) | (respValid & (Discard | !StallD)));
    assign grant    = IMemReq & IMemGnt;
    assign IMemAddr = PCF;

    assign loadD     = BufValid | respToD;
    assign loadInstr = BufValid ? BufInstr : IMemRdata;
    assign loadPC    = BufValid ? BufPC : ReqPC;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            PCF      <= RESET_PC;
            ReqPC    <= '0;
            BufPC    <= '0;
            BufInstr <= '0;
            BufValid <= 1'b0;
            Discard  <= 1'b0;
        end else begin
            if (PCSrcE)
                PCF <= PCTargetE;
            else if (grant)
                PCF <= PCF + FOUR;

            if (grant)
                ReqPC <= PCF;

            if (grant)
                state <= WAIT;
            else if (respValid)
                state <= IDLE;

            // An in-flight request from the old path must not reach decode.
            if (PCSrcE && state == WAIT && !IMemRvalid)
                Discard <= 1'b1;
            else if (respValid)
                Discard <= 1'b0;

            if (PCSrcE || FlushD)
                BufValid <= 1'b0;
            else if (bufCapture)
                BufValid <= 1'b1;
            else if (!StallD)
                BufValid <= 1'b0;

            if (bufCapture) begin
                BufInstr <= IMemRdata;
                BufPC    <= ReqPC;
            end
        end
    end

    if_id_reg #(
        .XLEN      (XLEN),
        .NOP_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk         (clk),
        .rst         (rst),
        .stall       (StallD),
        .flush       (FlushD),
        .load        (loadD),
        .loadInstr   (loadInstr),
        .loadPC      (loadPC),
        .loadPCPlus4 (loadPC + FOUR),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .ValidD      (ValidD)
    );

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage of the 5-stage pipelined core, directly upstream of decode and of the load-use hazard logic.
- Owns PCF and the IF/ID pipeline register.
- Issues requests to a variable-latency instruction memory with one request outstanding, and buffers one returned instruction while decode is stalled.
- Consumes StallF/StallD from hazard detection, and FlushD/PCSrcE/PCTargetE from the execute-stage branch logic.

Parameters:
XLEN, 32, PC/address width
RESET_PC, 32'h0000_0000, PCF value after reset
NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) driven on InstrD for bubbles

Ports:
clk  in  1  single clock, rising edge
rst  in  1  reset, asynchronous, active-high
StallF  in  1  hold PCF, issue no new request
StallD  in  1  hold IF/ID register
FlushD  in  1  load bubble into IF/ID
PCSrcE  in  1  redirect fetch this cycle
PCTargetE  in  XLEN  redirect target
IMemReq  out  1  request valid
IMemAddr  out  XLEN  request address, always equals PCF
IMemGnt  in  1  request accepted when IMemReq & IMemGnt
IMemRvalid  in  1  response valid, at least 1 cycle after grant
IMemRdata  in  32  response instruction
InstrD  out  32  decode-stage instruction
PCD  out  XLEN  PC of InstrD
PCPlus4D  out  XLEN  PCD+4
ValidD  out  1  InstrD is a real instruction

Behaviour:
- Reset (async, immediate): PCF=RESET_PC, state=IDLE, BufValid=0, Discard=0, ValidD=0, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, IMemReq=0.
- State: IDLE (nothing outstanding), WAIT (granted, awaiting response).
- Registers: ReqPC holds the PC of the outstanding request. Buffer holds {instr, pc}, qualified by BufValid.
- IMemReq = !StallF & !PCSrcE & !BufValid & (IDLE | (WAIT & IMemRvalid & (Discard | !StallD))).
  - This gives back-to-back issue: 1 instr/cycle with 1-cycle memory.
- Grant (IMemReq & IMemGnt):
  - ReqPC<=PCF, PCF<=PCF+4, next state WAIT.
  - IMemAddr must stay stable while IMemReq=1 and IMemGnt=0.
- Response in WAIT:
  - Discard=1: drop the response, clear Discard.
  - Else, !StallD and !FlushD: IF/ID<={IMemRdata, ReqPC, ReqPC+4, 1}.
  - Else, StallD: capture into the buffer, BufValid<=1.
  - Else, FlushD only: drop the response.
  - Next state: WAIT if a new request is granted this cycle, else IDLE.
- IMemRvalid while IDLE is ignored.
- IF/ID update priority:
  1. FlushD: bubble (ValidD=0, InstrD=NOP_INSTR, PCD/PCPlus4D hold). Overrides StallD; also clears BufValid.
  2. StallD: hold all fields.
  3. BufValid: load from the buffer, clear BufValid.
  4. Accepted response: load it.
  5. Otherwise: bubble.
- Redirect (PCSrcE=1):
  - PCF<=PCTargetE, overriding StallF and +4.
  - BufValid<=0.
  - WAIT with no response this cycle: Discard<=1.
  - Response in the same cycle: dropped.
  - No request is issued in the redirect cycle.
  - Top level drives FlushD with PCSrcE; this block does not infer it.
- StallF alone: PCF holds, no new request; an outstanding response is still accepted or buffered.
- Arithmetic: PC+4 wraps modulo 2^XLEN. PC[1:0] is not checked.
- Invariant: BufValid and WAIT are never both true (no request is issued while BufValid).

Decomposition:
- Shared pipeline package: NOP_INSTR, default RESET_PC, fetch state enum {IDLE, WAIT}.
- One sub-module: if_id_reg. It holds InstrD/PCD/PCPlus4D/ValidD with stall, flush and load-select inputs, and is reused for other stage registers.
- fetch_unit contains PCF, the FSM, ReqPC, the buffer and Discard.

Test Plan:
- Single-cycle memory (Gnt=1, Rvalid the cycle after grant), data 0x00500093, 0x00a00113, ... at 0x0, 0x4, 0x8 -> after reset release, Req addrs 0x0, 0x4, 0x8 on consecutive cycles; InstrD=0x00500093, PCD=0x0, PCPlus4D=0x4, ValidD=1, then one instruction per cycle.
- Response for 0x8 arrives during a 2-cycle StallD -> IF/ID holds 0x4 entry, BufValid=1, IMemReq=0; after StallD drops, InstrD gets the 0x8 instruction with PCD=0x8, and next Req addr=0xC.
- 3-cycle memory latency, PCSrcE=1 with PCTargetE=0x100 one cycle after grant of 0x10 -> 0x10 response dropped, next Req addr=0x100, ValidD=0 with InstrD=0x00000013 until the 0x100 response loads.
- PCSrcE coincident with IMemRvalid, target 0x40 -> response dropped, IMemReq=0 in that cycle, Req addr=0x40 next cycle.
- IMemGnt low 3 cycles -> IMemReq=1 with IMemAddr constant, ValidD=0 bubbles in D, PCF unchanged.
- rst asserted mid-WAIT between edges -> outputs reach reset values without a clock edge; a later IMemRvalid is ignored; first post-reset Req addr=RESET_PC.
